// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the memory system.
//   req    : bus request, held until gnt
//   we     : write strobe (store)
//   addr   : word address, bits [1:0] always 00
//   wdata  : store data, replicated across lanes for sub-word stores
//   be     : byte enables
//   gnt    : request accepted
//   rvalid : read data valid
//   rdata  : read data word
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: passes non-memory results straight to the register file and runs a single
// outstanding LOAD or STORE on the data-memory bus, with alignment/func3 checks and a
// grant/read-data timeout.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid             : instruction valid from decode/execute
//   opcode, func3        : instruction opcode and access size/sign
//   wb_reg, rd_num       : instruction writes rd, destination register
//   rd_data              : ALU result (effective address for memory ops)
//   rs2_data             : store data
//   stall                : upstream holds its inputs while high
//   dmem                 : data-memory bus (master side)
//   reg_we/wnum/wdata    : register-file write port
//   fault                : one-cycle pulse on misalign, illegal func3 or timeout
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [6:0]               opcode,
    input  logic [2:0]               func3,
    input  logic                     wb_reg,
    input  logic [4:0]               rd_num,
    input  logic [31:0]              rd_data,
    input  logic [31:0]              rs2_data,
    output logic                     stall,
    load_store_unit_if.master        dmem,
    output logic                     reg_we,
    output logic [4:0]               reg_wnum,
    output logic [31:0]              reg_wdata,
    output logic                     fault
);
    localparam logic [6:0] OpLoad      = 7'b0000011;
    localparam logic [6:0] OpStore     = 7'b0100011;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, sdata_q, ldata_q, ldata_d;
    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        store_q, fault_q, fault_d, capture;

    logic        is_load, is_store, func3_ok, aligned, mem_ok;
    logic        stall_c, reg_we_c;
    logic [4:0]  reg_wnum_c;
    logic [31:0] reg_wdata_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        in_req;

    // Byte/half lane select by address offset, then sign or zero extension.
    function automatic logic [31:0] extract(logic [2:0] f3, logic [1:0] off, logic [31:0] word);
        logic [31:0] sh;
        logic [15:0] half;
        logic [31:0] res;
        sh   = word >> {off, 3'b000};
        half = off[1] ? word[31:16] : word[15:0];
        unique case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{half[15]}}, half};
            3'b100:  res = {24'h0, sh[7:0]};
            3'b101:  res = {16'h0, half};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode and legality of the incoming instruction.
    always_comb begin
        is_load  = opcode == OpLoad;
        is_store = opcode == OpStore;
        if (is_store) begin
            func3_ok = func3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            func3_ok = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (func3[1:0])
            2'b01:   aligned = ~rd_data[0];
            2'b10:   aligned = rd_data[1:0] == 2'b00;
            default: aligned = 1'b1;
        endcase
        mem_ok = func3_ok & aligned;
    end

    // Store lanes from the latched request.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = '0;
        case (func3_q[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_c = {2{sdata_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = sdata_q;
            end
        endcase
    end

    // Next-state and outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        fault_d     = 1'b0;
        capture     = 1'b0;
        ldata_d     = ldata_q;
        stall_c     = 1'b0;
        reg_we_c    = 1'b0;
        reg_wnum_c  = '0;
        reg_wdata_c = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_load || is_store) begin
                        if (mem_ok) begin
                            stall_c = 1'b1;
                            capture = 1'b1;
                            state_d = StReq;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        reg_we_c    = wb_reg && (rd_num != 5'd0);
                        reg_wnum_c  = rd_num;
                        reg_wdata_c = rd_data;
                    end
                end
            end
            StReq: begin
                stall_c = 1'b1;
                if (dmem.gnt) begin
                    if (store_q) begin
                        stall_c = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    stall_c = 1'b0;
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWait: begin
                stall_c = 1'b1;
                if (dmem.rvalid) begin
                    ldata_d = extract(func3_q, addr_q[1:0], dmem.rdata);
                    state_d = StWb;
                end else if (cnt_q == TimeoutLast) begin
                    stall_c = 1'b0;
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb: begin
                reg_we_c    = rd_q != 5'd0;
                reg_wnum_c  = rd_q;
                reg_wdata_c = ldata_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
            func3_q <= '0;
            rd_q    <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ldata_q <= ldata_d;
            if (capture) begin
                addr_q  <= rd_data;
                sdata_q <= rs2_data;
                func3_q <= func3;
                rd_q    <= rd_num;
                store_q <= is_store;
            end
        end
    end

    assign in_req     = state_q == StReq;
    assign dmem.req   = in_req;
    assign dmem.we    = in_req & store_q;
    assign dmem.addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign dmem.be    = in_req ? be_c : '0;
    assign dmem.wdata = (in_req & store_q) ? wdata_c : '0;

    // Outputs fed combinationally from upstream inputs are forced low while reset is held.
    assign stall     = rst_n & stall_c;
    assign reg_we    = rst_n & reg_we_c;
    assign reg_wnum  = rst_n ? reg_wnum_c : '0;
    assign reg_wdata = rst_n ? reg_wdata_c : '0;
    assign fault     = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized transactions,
// each checked cycle by cycle against expectations derived from the access rules.
module tb_load_store_unit;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic        wb_reg = 1'b0;
    logic [4:0]  rd_num = '0;
    logic [31:0] rd_data = '0;
    logic [31:0] rs2_data = '0;
    logic        stall;
    logic        reg_we;
    logic [4:0]  reg_wnum;
    logic [31:0] reg_wdata;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit_if dmem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .func3     (func3),
        .wb_reg    (wb_reg),
        .rd_num    (rd_num),
        .rd_data   (rd_data),
        .rs2_data  (rs2_data),
        .stall     (stall),
        .dmem      (dmem_bus),
        .reg_we    (reg_we),
        .reg_wnum  (reg_wnum),
        .reg_wdata (reg_wdata),
        .fault     (fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction from IDLE back to IDLE. kind: 0 ALU, 1 LOAD, 2 STORE.
    // gdly/rdly: cycles in REQ/WAIT before gnt/rvalid (>= T never arrives).
    task automatic run_txn(input int kind, input logic [2:0] f3, input logic [4:0] rd,
                           input logic wb, input logic [31:0] addr, input logic [31:0] rs2,
                           input int gdly, input int rdly, input logic [31:0] rdata);
        logic [31:0] off, sz, exp_be, exp_wd, v;
        bit          legal, aligned, granted, got_data;
        off = {30'd0, addr[1:0]};
        sz  = {30'd0, f3[1:0]};
        if (kind == 2) legal = f3 <= 3'd2;
        else legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        aligned = (sz == 0) || (sz == 1 && addr % 2 == 0) || (sz == 2 && addr % 4 == 0);
        exp_be  = (sz == 0) ? (32'd1 << off) : (sz == 1) ? (32'd3 << off) : 32'd15;
        exp_wd  = (sz == 0) ? (rs2 & 32'hFF) * 32'h01010101 :
                  (sz == 1) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
        v = rdata >> (8 * off);
        if (f3 == 3'd0 || f3 == 3'd4) v = v & 32'hFF;
        if (f3 == 3'd1 || f3 == 3'd5) v = v & 32'hFFFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;

        in_valid = 1'b1;
        opcode   = (kind == 1) ? 7'b0000011 : (kind == 2) ? 7'b0100011 : 7'b0110011;
        func3    = f3;
        rd_num   = rd;
        wb_reg   = wb;
        rd_data  = addr;
        rs2_data = rs2;
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = $urandom;
        @(negedge clk);
        check_eq("idle_fault", fault, 0);
        check_eq("idle_req", dmem_bus.req, 0);
        if (kind == 0) begin
            check_eq("alu_stall", stall, 0);
            check_eq("alu_we", reg_we, wb && rd != 0);
            if (wb && rd != 0) begin
                check_eq("alu_wnum", reg_wnum, rd);
                check_eq("alu_wdata", reg_wdata, addr);
            end
            next_cycle();
            in_valid = 1'b0;
            return;
        end
        check_eq("idle_stall", stall, legal && aligned);
        check_eq("idle_we", reg_we, 0);
        next_cycle();
        if (!(legal && aligned)) begin
            in_valid = 1'b0;
            @(negedge clk);
            check_eq("bad_fault", fault, 1);
            check_eq("bad_req", dmem_bus.req, 0);
            check_eq("bad_we", reg_we, 0);
            next_cycle();
            @(negedge clk);
            check_eq("bad_fault_end", fault, 0);
            next_cycle();
            return;
        end

        granted = 0;
        for (int k = 0; k < int'(T); k++) begin
            dmem_bus.gnt    = (k == gdly);
            dmem_bus.rvalid = 1'($urandom);
            @(negedge clk);
            check_eq("req_req", dmem_bus.req, 1);
            check_eq("req_addr", dmem_bus.addr, addr & ~32'd3);
            check_eq("req_we", dmem_bus.we, kind == 2);
            if (kind == 2) begin
                check_eq("req_be", dmem_bus.be, exp_be);
                check_eq("req_wdata", dmem_bus.wdata, exp_wd);
            end
            if (k == gdly) check_eq("req_stall", stall, kind == 1);
            else check_eq("req_stall", stall, k != int'(T) - 1);
            check_eq("req_regwe", reg_we, 0);
            next_cycle();
            dmem_bus.gnt    = 1'b0;
            dmem_bus.rvalid = 1'b0;
            if (k == gdly) begin
                granted = 1;
                break;
            end
        end

        got_data = 0;
        if (granted && kind == 1) begin
            for (int j = 0; j < int'(T); j++) begin
                dmem_bus.rvalid = (j == rdly);
                dmem_bus.gnt    = 1'($urandom);
                dmem_bus.rdata  = (j == rdly) ? rdata : $urandom;
                @(negedge clk);
                check_eq("wait_req", dmem_bus.req, 0);
                if (j == rdly) check_eq("wait_stall", stall, 1);
                else check_eq("wait_stall", stall, j != int'(T) - 1);
                check_eq("wait_regwe", reg_we, 0);
                next_cycle();
                dmem_bus.rvalid = 1'b0;
                dmem_bus.gnt    = 1'b0;
                if (j == rdly) begin
                    got_data = 1;
                    break;
                end
            end
        end

        if (granted && kind == 2) begin
            in_valid = 1'b0;
            @(negedge clk);
            check_eq("st_done_req", dmem_bus.req, 0);
            check_eq("st_done_fault", fault, 0);
            check_eq("st_done_we", reg_we, 0);
            next_cycle();
        end else if (got_data) begin
            dmem_bus.rdata = $urandom;
            @(negedge clk);
            check_eq("wb_we", reg_we, rd != 0);
            if (rd != 0) begin
                check_eq("wb_wnum", reg_wnum, rd);
                check_eq("wb_wdata", reg_wdata, v);
            end
            check_eq("wb_stall", stall, 0);
            check_eq("wb_req", dmem_bus.req, 0);
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            check_eq("post_wb_we", reg_we, 0);
            check_eq("post_wb_fault", fault, 0);
            next_cycle();
        end else begin
            // Timeout: fault pulse, then a stray rvalid must not reach the register file.
            in_valid        = 1'b0;
            dmem_bus.rvalid = 1'b1;
            @(negedge clk);
            check_eq("to_fault", fault, 1);
            check_eq("to_req", dmem_bus.req, 0);
            check_eq("to_stall", stall, 0);
            check_eq("to_we", reg_we, 0);
            next_cycle();
            @(negedge clk);
            check_eq("to_fault_end", fault, 0);
            check_eq("to_stray_we", reg_we, 0);
            dmem_bus.rvalid = 1'b0;
            next_cycle();
        end
    endtask

    initial begin
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = '0;
        // Reset state with a writable ALU op presented: everything stays low.
        in_valid = 1'b1;
        opcode   = 7'b0110011;
        wb_reg   = 1'b1;
        rd_num   = 5'd7;
        rd_data  = 32'h1234_5678;
        @(negedge clk);
        check_eq("rst_we", reg_we, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_req", dmem_bus.req, 0);
        check_eq("rst_fault", fault, 0);
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        run_txn(2, 3'b000, 5'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 2, 0, 32'h0);
        run_txn(1, 3'b000, 5'd5, 1'b1, 32'h0000_2001, 32'h0, 0, 1, 32'h0000_8000);
        run_txn(1, 3'b100, 5'd5, 1'b1, 32'h0000_2001, 32'h0, 1, 0, 32'h0000_8000);
        run_txn(1, 3'b010, 5'd6, 1'b1, 32'h0000_2002, 32'h0, 0, 0, 32'h0);
        run_txn(1, 3'b010, 5'd3, 1'b1, 32'h0000_3000, 32'h0, 99, 0, 32'h0);
        run_txn(1, 3'b010, 5'd3, 1'b1, 32'h0000_3004, 32'h0, 0, 99, 32'h0);
        run_txn(0, 3'b000, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0);
        run_txn(0, 3'b000, 5'd7, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 0, 32'h0);
        run_txn(2, 3'b001, 5'd0, 1'b0, 32'h0000_4002, 32'h1234_BEEF, 0, 0, 32'h0);
        run_txn(2, 3'b011, 5'd0, 1'b0, 32'h0000_4000, 32'h0, 0, 0, 32'h0);

        // Reset asserted while the load waits for read data.
        in_valid = 1'b1;
        opcode   = 7'b0000011;
        func3    = 3'b010;
        rd_num   = 5'd9;
        rd_data  = 32'h0000_5000;
        next_cycle();
        dmem_bus.gnt = 1'b1;
        next_cycle();
        dmem_bus.gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_req", dmem_bus.req, 0);
        check_eq("rstw_stall", stall, 0);
        check_eq("rstw_we", reg_we, 0);
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("rstw_stray_stall", stall, 0);
        check_eq("rstw_stray_we", reg_we, 0);
        next_cycle();
        dmem_bus.rvalid = 1'b0;
        @(negedge clk);
        check_eq("rstw_after_we", reg_we, 0);
        check_eq("rstw_after_fault", fault, 0);
        next_cycle();

        for (int i = 0; i < 300; i++) begin
            run_txn(int'($urandom_range(0, 2)), 3'($urandom), 5'($urandom), 1'($urandom),
                    $urandom, $urandom, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
